// File: rtl/rr_mux_arbiter_4_pkg.sv
// Shared types and helpers for the four-way round-robin mux arbiter.
package arb_pkg;

   localparam int unsigned N_REQ = 4;

   typedef logic [1:0] src_t;

   // Output register occupancy
   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } out_state_e;

   // Priority pointer successor; wraps 3 -> 0 through the 2-bit type
   function automatic src_t rr_next(input src_t x);
      return src_t'(x + src_t'(1));
   endfunction

endpackage

// File: rtl/rr_mux_arbiter_4_pick.sv
// Combinational round-robin pick: rotate requests so ptr sits at bit 0,
// take the lowest set bit, then rotate the offset back to a source index.
module rr_pick_4
   import arb_pkg::*;
(
   input  logic [3:0] req,
   input  src_t       ptr,
   output src_t       grant,
   output logic       any
);

   logic [3:0] rot;
   src_t       off;
   src_t       idx;
   logic       found;

   // Rotate by ptr and fixed-priority encode the rotated vector
   always_comb begin
      rot   = '0;
      off   = '0;
      idx   = '0;
      found = 1'b0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         idx    = src_t'(ptr + src_t'(k));
         rot[k] = req[idx];
      end
      for (int unsigned k = 0; k < N_REQ; k++) begin
         if (!found && rot[k]) begin
            off   = src_t'(k);
            found = 1'b1;
         end
      end
      grant = src_t'(ptr + off);
      any   = |req;
   end

endmodule

// File: rtl/rr_mux_arbiter_4.sv
// Four-way round-robin arbiter sharing one WIDTH-bit 4:1 select path,
// with a one-entry registered output stage and source tag.
module rr_mux_arbiter_4
   import arb_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in_data [0:3],
   input  logic [3:0]       in_valid,
   output logic [3:0]       in_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       out_src,
   output logic             out_valid,
   input  logic             out_ready
);

   out_state_e       state_q, state_d;
   logic [WIDTH-1:0] data_q, data_d;
   src_t             src_q, src_d;
   src_t             ptr_q, ptr_d;

   src_t             grant;
   logic             gnt_any;
   logic             can_load;
   logic             accept;
   logic [WIDTH-1:0] sel_data;

   rr_pick_4 u_pick (
      .req   (in_valid),
      .ptr   (ptr_q),
      .grant (grant),
      .any   (gnt_any)
   );

   assign out_valid = (state_q == ST_FULL);
   assign out_data  = data_q;
   assign out_src   = src_q;
   assign can_load  = !out_valid || out_ready;
   assign accept    = gnt_any && can_load;

   // Steer only the granted payload; other lanes never reach the register
   always_comb begin
      sel_data = in_data[grant];
   end

   // One-hot ready to the granted requester; held low while in reset
   always_comb begin
      in_ready = '0;
      if (accept && rst_n) begin
         in_ready[grant] = 1'b1;
      end
   end

   // Next state: load on accept (covers simultaneous drain), else drain
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      src_d   = src_q;
      ptr_d   = ptr_q;
      if (accept) begin
         state_d = ST_FULL;
         data_d  = sel_data;
         src_d   = grant;
         ptr_d   = rr_next(grant);
      end else if (out_valid && out_ready) begin
         state_d = ST_EMPTY;
      end
   end

   // Output stage and priority pointer registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_EMPTY;
         data_q  <= '0;
         src_q   <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         src_q   <= src_d;
         ptr_q   <= ptr_d;
      end
   end

endmodule

// File: tb/tb_rr_mux_arbiter_4.sv
// Directed bench for rr_mux_arbiter_4: reset, rotation, backpressure,
// lone requester, X isolation with skip, and reset mid-operation.
module tb_rr_mux_arbiter_4;

   localparam int unsigned W = 8;
   localparam logic [W-1:0] A = 8'hA1;
   localparam logic [W-1:0] B = 8'hB2;
   localparam logic [W-1:0] C = 8'hC3;
   localparam logic [W-1:0] D = 8'hD4;

   logic         clk;
   logic         rst_n;
   logic [W-1:0] in_data [0:3];
   logic [3:0]   in_valid;
   logic [3:0]   in_ready;
   logic [W-1:0] out_data;
   logic [1:0]   out_src;
   logic         out_valid;
   logic         out_ready;

   int checks;
   int failures;

   rr_mux_arbiter_4 #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_src   (out_src),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_abcd();
      in_data[0] = A;
      in_data[1] = B;
      in_data[2] = C;
      in_data[3] = D;
   endtask

   task automatic do_reset(input int cycles);
      rst_n = 1'b0;
      for (int i = 0; i < cycles; i++) tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      set_abcd();
      in_valid  = 4'b1111;
      out_ready = 1'b1;
      rst_n     = 1'b0;
      for (int i = 0; i < 2; i++) begin
         #1;
         checks++;
         if (in_ready !== 4'b0000) begin
            failures++;
            $display("FAIL reset_in_ready cyc=%0d got=%b exp=0000", i, in_ready);
         end
         tick();
      end
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_out_valid got=%b exp=0", out_valid);
      end
      checks++;
      if (out_data !== '0) begin
         failures++;
         $display("FAIL reset_out_data got=%h exp=00", out_data);
      end
      checks++;
      if (out_src !== 2'd0) begin
         failures++;
         $display("FAIL reset_out_src got=%0d exp=0", out_src);
      end
      rst_n = 1'b1;
      #1;
      checks++;
      if (in_ready !== 4'b0001) begin
         failures++;
         $display("FAIL reset_first_ready got=%b exp=0001", in_ready);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_src !== 2'd0 || out_data !== A) begin
         failures++;
         $display("FAIL reset_first_accept got=v%b s%0d d%h exp=v1 s0 d%h",
                  out_valid, out_src, out_data, A);
      end
   endtask

   task automatic test_rotation();
      logic [3:0]   exp_rdy [0:4];
      logic [1:0]   exp_src [0:4];
      logic [W-1:0] exp_dat [0:4];
      exp_rdy[0] = 4'b0001; exp_src[0] = 2'd0; exp_dat[0] = A;
      exp_rdy[1] = 4'b0010; exp_src[1] = 2'd1; exp_dat[1] = B;
      exp_rdy[2] = 4'b0100; exp_src[2] = 2'd2; exp_dat[2] = C;
      exp_rdy[3] = 4'b1000; exp_src[3] = 2'd3; exp_dat[3] = D;
      exp_rdy[4] = 4'b0001; exp_src[4] = 2'd0; exp_dat[4] = A;
      set_abcd();
      in_valid  = 4'b0000;
      out_ready = 1'b1;
      do_reset(1);
      in_valid = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         #1;
         checks++;
         if (in_ready !== exp_rdy[i]) begin
            failures++;
            $display("FAIL rot_ready step=%0d got=%b exp=%b", i, in_ready, exp_rdy[i]);
         end
         tick();
         checks++;
         if (out_valid !== 1'b1 || out_src !== exp_src[i] || out_data !== exp_dat[i]) begin
            failures++;
            $display("FAIL rot_out step=%0d got=v%b s%0d d%h exp=v1 s%0d d%h",
                     i, out_valid, out_src, out_data, exp_src[i], exp_dat[i]);
         end
      end
   endtask

   task automatic test_backpressure();
      set_abcd();
      in_valid  = 4'b0000;
      out_ready = 1'b1;
      do_reset(1);
      in_valid = 4'b1111;
      tick();
      tick();
      checks++;
      if (out_src !== 2'd1 || out_data !== B) begin
         failures++;
         $display("FAIL bp_setup got=s%0d d%h exp=s1 d%h", out_src, out_data, B);
      end
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if (in_ready !== 4'b0000) begin
            failures++;
            $display("FAIL bp_ready cyc=%0d got=%b exp=0000", i, in_ready);
         end
         tick();
         checks++;
         if (out_valid !== 1'b1 || out_src !== 2'd1 || out_data !== B) begin
            failures++;
            $display("FAIL bp_hold cyc=%0d got=v%b s%0d d%h exp=v1 s1 d%h",
                     i, out_valid, out_src, out_data, B);
         end
      end
      out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 4'b0100) begin
         failures++;
         $display("FAIL bp_release_ready got=%b exp=0100", in_ready);
      end
      tick();
      checks++;
      if (out_src !== 2'd2 || out_data !== C) begin
         failures++;
         $display("FAIL bp_release_out got=s%0d d%h exp=s2 d%h", out_src, out_data, C);
      end
   endtask

   task automatic test_lone();
      set_abcd();
      in_data[2] = W'(7);
      in_valid   = 4'b0000;
      out_ready  = 1'b1;
      do_reset(1);
      in_valid = 4'b0100;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if (in_ready !== 4'b0100) begin
            failures++;
            $display("FAIL lone_ready cyc=%0d got=%b exp=0100", i, in_ready);
         end
         tick();
         checks++;
         if (out_valid !== 1'b1 || out_src !== 2'd2 || out_data !== W'(7)) begin
            failures++;
            $display("FAIL lone_out cyc=%0d got=v%b s%0d d%h exp=v1 s2 d07",
                     i, out_valid, out_src, out_data);
         end
      end
      in_valid = 4'b0000;
      #1;
      checks++;
      if (in_ready !== 4'b0000) begin
         failures++;
         $display("FAIL lone_idle_ready got=%b exp=0000", in_ready);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0 || out_src !== 2'd2 || out_data !== W'(7)) begin
         failures++;
         $display("FAIL lone_drain got=v%b s%0d d%h exp=v0 s2 d07",
                  out_valid, out_src, out_data);
      end
   endtask

   task automatic test_x_skip();
      logic [1:0]   exp_src [0:2];
      logic [W-1:0] exp_dat [0:2];
      exp_src[0] = 2'd0; exp_dat[0] = W'(7);
      exp_src[1] = 2'd1; exp_dat[1] = W'(10);
      exp_src[2] = 2'd2; exp_dat[2] = W'(3);
      set_abcd();
      in_valid  = 4'b0000;
      out_ready = 1'b1;
      do_reset(1);
      // one accept from requester 2 leaves ptr at 3
      in_valid = 4'b0100;
      tick();
      in_data[0] = W'(7);
      in_data[1] = W'(10);
      in_data[2] = W'(3);
      in_data[3] = 'x;
      in_valid   = 4'b0111;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (out_src !== exp_src[i] || out_data !== exp_dat[i] || $isunknown(out_data)) begin
            failures++;
            $display("FAIL xskip step=%0d got=s%0d d%h exp=s%0d d%h",
                     i, out_src, out_data, exp_src[i], exp_dat[i]);
         end
      end
   endtask

   task automatic test_reset_mid();
      set_abcd();
      in_data[1] = 8'h55;
      in_data[3] = 8'h66;
      in_valid   = 4'b0000;
      out_ready  = 1'b1;
      do_reset(1);
      in_valid = 4'b0010;
      tick();
      out_ready = 1'b0;
      in_valid  = 4'b1000;
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h55) begin
         failures++;
         $display("FAIL mid_setup got=v%b d%h exp=v1 d55", out_valid, out_data);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (in_ready !== 4'b0000) begin
         failures++;
         $display("FAIL mid_rst_ready got=%b exp=0000", in_ready);
      end
      tick();
      rst_n     = 1'b1;
      in_valid  = 4'b0000;
      out_ready = 1'b1;
      checks++;
      if (out_valid !== 1'b0 || out_data !== '0 || out_src !== 2'd0) begin
         failures++;
         $display("FAIL mid_rst_state got=v%b s%0d d%h exp=v0 s0 d00",
                  out_valid, out_src, out_data);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL mid_no_ghost got=v%b d%h exp=v0", out_valid, out_data);
      end
      set_abcd();
      in_valid = 4'b1111;
      tick();
      checks++;
      if (out_src !== 2'd0 || out_data !== A) begin
         failures++;
         $display("FAIL mid_ptr_zero got=s%0d d%h exp=s0 d%h", out_src, out_data, A);
      end
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      rst_n     = 1'b0;
      in_valid  = 4'b0000;
      out_ready = 1'b0;
      set_abcd();
      test_reset();
      test_rotation();
      test_backpressure();
      test_lone();
      test_x_skip();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
